// File: rtl/phy_reg_free_list_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : phy_reg_free_list_if
// Purpose  : Allocate/release bundle between rename, commit and the scalar
//            physical register free list.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface phy_reg_free_list_if #(
  parameter int POP_WIDTH  = 2,
  parameter int PUSH_WIDTH = 2,
  parameter int REG_W      = 6,
  parameter int CNT_W      = 6
);
  logic [POP_WIDTH-1:0]             popReq;
  logic [POP_WIDTH-1:0][REG_W-1:0]  popRegNum;
  logic                             canPop;
  logic [PUSH_WIDTH-1:0]            pushReq;
  logic [PUSH_WIDTH-1:0][REG_W-1:0] pushRegNum;
  logic [CNT_W-1:0]                 count;
  logic                             errUnderflow;
  logic                             errOverflow;

  // Rename/commit side
  modport master (
    output popReq, pushReq, pushRegNum,
    input  popRegNum, canPop, count, errUnderflow, errOverflow
  );

  // Free list side
  modport slave (
    input  popReq, pushReq, pushRegNum,
    output popRegNum, canPop, count, errUnderflow, errOverflow
  );
endinterface
`default_nettype wire

// File: rtl/phy_reg_free_list.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : phy_reg_free_list
// Purpose  : Circular free list of scalar physical register numbers. Grants
//            up to POP_WIDTH compacted registers per cycle to rename and takes
//            back up to PUSH_WIDTH released registers per cycle from commit.
// Revision : 1.0
// ----------------------------------------------------------------------------
module phy_reg_free_list #(
  parameter int ENTRY_NUM  = 32,
  parameter int POP_WIDTH  = 2,
  parameter int PUSH_WIDTH = 2,
  parameter int FIRST_FREE = 32,
  parameter int REG_W      = 6,
  parameter int CNT_W      = $clog2(ENTRY_NUM + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  phy_reg_free_list_if.slave fl
);

  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  // Wide enough for pointer + lane offset and for count + pushes
  localparam int SUM_W = $clog2(ENTRY_NUM + POP_WIDTH + PUSH_WIDTH + 1) + 1;
  localparam logic [SUM_W-1:0] ENTRY_S = SUM_W'(ENTRY_NUM);
  localparam logic [SUM_W-1:0] POP_S   = SUM_W'(POP_WIDTH);

  logic [REG_W-1:0] entry [ENTRY_NUM];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] free_cnt;
  logic             under_err;
  logic             over_err;

  logic [SUM_W-1:0] pop_off  [POP_WIDTH];
  logic [SUM_W-1:0] push_off [PUSH_WIDTH];
  logic [SUM_W-1:0] n_pop;
  logic [SUM_W-1:0] n_push;
  logic [SUM_W-1:0] pop_acc;
  logic [SUM_W-1:0] push_acc;
  logic [SUM_W-1:0] cnt_after_pop;
  logic             pop_ok;
  logic             push_ok;

  // Operands never exceed 2*ENTRY_NUM-1, so one conditional subtract wraps
  // correctly for any ENTRY_NUM, power of two or not.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] r;
    r = (s >= ENTRY_S) ? s - ENTRY_S : s;
    return PTR_W'(r);
  endfunction

  // Prefix popcounts give each requesting lane its compacted slot offset
  always_comb begin
    n_pop  = '0;
    n_push = '0;
    for (int k = 0; k < POP_WIDTH; k++) begin
      pop_off[k] = n_pop;
      n_pop      = n_pop + SUM_W'(fl.popReq[k]);
    end
    for (int j = 0; j < PUSH_WIDTH; j++) begin
      push_off[j] = n_push;
      n_push      = n_push + SUM_W'(fl.pushReq[j]);
    end
  end

  // Accept decisions: pop is judged on the pre-push count, push on the count
  // left after accepted pops
  always_comb begin
    pop_ok        = (n_pop <= SUM_W'(free_cnt));
    pop_acc       = pop_ok ? n_pop : '0;
    cnt_after_pop = SUM_W'(free_cnt) - pop_acc;
    push_ok       = ((cnt_after_pop + n_push) <= ENTRY_S);
    push_acc      = push_ok ? n_push : '0;
  end

  // Zero-latency read of the granted registers from pre-edge contents
  always_comb begin
    for (int k = 0; k < POP_WIDTH; k++) begin
      fl.popRegNum[k] = entry[wrap_idx(SUM_W'(head_ptr) + pop_off[k])];
    end
  end

  assign fl.canPop       = (SUM_W'(free_cnt) >= POP_S);
  assign fl.count        = free_cnt;
  assign fl.errUnderflow = under_err;
  assign fl.errOverflow  = over_err;

  // Pointer, count, sticky error and storage update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        entry[i] <= REG_W'(FIRST_FREE + i);
      end
      head_ptr  <= '0;
      tail_ptr  <= '0;
      free_cnt  <= CNT_W'(ENTRY_NUM);
      under_err <= 1'b0;
      over_err  <= 1'b0;
    end else begin
      head_ptr <= wrap_idx(SUM_W'(head_ptr) + pop_acc);
      tail_ptr <= wrap_idx(SUM_W'(tail_ptr) + push_acc);
      free_cnt <= CNT_W'(cnt_after_pop + push_acc);
      if (!pop_ok) begin
        under_err <= 1'b1;
      end
      if (!push_ok) begin
        over_err <= 1'b1;
      end
      if (push_ok) begin
        for (int j = 0; j < PUSH_WIDTH; j++) begin
          if (fl.pushReq[j]) begin
            entry[wrap_idx(SUM_W'(tail_ptr) + push_off[j])] <= fl.pushRegNum[j];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phy_reg_free_list.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_phy_reg_free_list
// Purpose  : Self-checking bench for phy_reg_free_list with a reference FIFO
//            model and a scoreboard of expected granted registers.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_phy_reg_free_list;

  localparam int EN = 32;
  localparam int PW = 2;
  localparam int UW = 2;
  localparam int FF = 32;
  localparam int RW = 6;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running clock
  always #5 clk = ~clk;

  phy_reg_free_list_if #(.POP_WIDTH(PW), .PUSH_WIDTH(UW), .REG_W(RW), .CNT_W(CW)) fl();

  phy_reg_free_list #(
    .ENTRY_NUM(EN), .POP_WIDTH(PW), .PUSH_WIDTH(UW),
    .FIRST_FREE(FF), .REG_W(RW), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mdl[$];     // reference free list contents, head first
  int alloc[$];   // registers currently handed out
  int exp_q[$];   // scoreboard of expected grants
  bit in_flight [64];
  bit m_under;
  bit m_over;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl.delete();
    for (int i = 0; i < EN; i++) mdl.push_back(FF + i);
    alloc.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) in_flight[i] = 1'b0;
    m_under = 1'b0;
    m_over  = 1'b0;
  endtask

  task automatic do_reset();
    fl.popReq     = '0;
    fl.pushReq    = '0;
    fl.pushRegNum = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Reset image: both lanes requested show FIRST_FREE, FIRST_FREE+1
  task automatic image_check();
    fl.popReq = 2'b11;
    #1;
    check("rst_lane0", fl.popRegNum[0], FF);
    check("rst_lane1", fl.popRegNum[1], FF + 1);
    check("rst_count", fl.count, EN);
    check("rst_canPop", fl.canPop, 1);
    check("rst_errUnderflow", fl.errUnderflow, 0);
    check("rst_errOverflow", fl.errOverflow, 0);
    fl.popReq = 2'b00;
  endtask

  // One clock: drive, compare at negedge, advance the model, step the edge
  task automatic cycle(input logic [1:0] pop, input logic [1:0] push,
                       input logic [5:0] r0, input logic [5:0] r1);
    int n_pop;
    int n_push;
    int e;
    fl.popReq        = pop;
    fl.pushReq       = push;
    fl.pushRegNum[0] = r0;
    fl.pushRegNum[1] = r1;
    @(negedge clk);
    check("count", fl.count, mdl.size());
    check("canPop", fl.canPop, (mdl.size() >= PW) ? 1 : 0);
    check("errUnderflow", fl.errUnderflow, m_under);
    check("errOverflow", fl.errOverflow, m_over);
    n_pop  = int'(pop[0]) + int'(pop[1]);
    n_push = int'(push[0]) + int'(push[1]);
    if (n_pop <= mdl.size()) begin
      for (int k = 0; k < PW; k++) if (pop[k]) exp_q.push_back(mdl.pop_front());
      for (int k = 0; k < PW; k++) begin
        if (pop[k]) begin
          e = exp_q.pop_front();
          check($sformatf("popRegNum[%0d]", k), fl.popRegNum[k], e);
          check("dup_grant", in_flight[e], 0);
          in_flight[e] = 1'b1;
          alloc.push_back(e);
        end
      end
    end else begin
      m_under = 1'b1;
    end
    if (mdl.size() + n_push <= EN) begin
      if (push[0]) mdl.push_back(int'(r0));
      if (push[1]) mdl.push_back(int'(r1));
    end else begin
      m_over = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] pop;
    logic [1:0] push;
    logic [5:0] rv [2];
    int idx;

    rst_n         = 1'b0;
    fl.popReq     = '0;
    fl.pushReq    = '0;
    fl.pushRegNum = '0;
    do_reset();

    // Reset image, then drain in pairs: 32..63 in order
    image_check();
    for (int c = 0; c < 16; c++) cycle(2'b11, 2'b00, 6'd0, 6'd0);
    // Empty: pop rejected, same-cycle push of {5,7} accepted
    cycle(2'b01, 2'b11, 6'd5, 6'd7);
    // Pushed registers visible only now, lane0=5, lane1=7
    cycle(2'b11, 2'b00, 6'd0, 6'd0);
    cycle(2'b00, 2'b00, 6'd0, 6'd0);

    // Upper lane alone takes the head, then lane0 takes the next
    do_reset();
    cycle(2'b10, 2'b00, 6'd0, 6'd0);
    cycle(2'b01, 2'b00, 6'd0, 6'd0);
    cycle(2'b00, 2'b00, 6'd0, 6'd0);

    // Push into full list: rejected, contents intact
    do_reset();
    cycle(2'b00, 2'b01, 6'd40, 6'd0);
    for (int c = 0; c < 16; c++) cycle(2'b11, 2'b00, 6'd0, 6'd0);

    // Random traffic with released registers recirculated, reset midway
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      if (c == 500) begin
        do_reset();
        image_check();
      end
      pop   = 2'($urandom_range(0, 3));
      push  = 2'b00;
      rv[0] = 6'($urandom);
      rv[1] = 6'($urandom);
      for (int j = 0; j < UW; j++) begin
        if ($urandom_range(0, 99) < 55 && alloc.size() > 0) begin
          idx   = $urandom_range(0, alloc.size() - 1);
          rv[j] = 6'(alloc[idx]);
          alloc.delete(idx);
          in_flight[rv[j]] = 1'b0;
          push[j] = 1'b1;
        end
      end
      cycle(pop, push, rv[0], rv[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
